// File: rtl/game_pkg.sv
// Shared game-flow definitions: state encodings, display indices, sizing helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package game_pkg;

    // One-hot so every bit maps directly onto a display enable, and so that
    // every other code point is detectably illegal.
    typedef enum logic [3:0] {
        ST_HOME  = 4'b0001,
        ST_GAME  = 4'b0010,
        ST_PAUSE = 4'b0100,
        ST_END   = 4'b1000
    } state_t;

    // Bit positions of each state inside state_t / display enable vector.
    localparam int DISP_HOME  = 0;
    localparam int DISP_GAME  = 1;
    localparam int DISP_PAUSE = 2;
    localparam int DISP_END   = 3;

    // Width of a player index; a single player still needs one bit.
    function automatic int win_w(input int n_players);
        return (n_players > 1) ? $clog2(n_players) : 1;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for a switch level.
// Latency: o_rise is combinational from the level and the previous-value register.
// Backpressure: none; a level held high through reset release never produces an edge.
module btn_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_lvl,
    output logic o_rise
);

    logic r_prev;
    logic r_armed;

    // Capture the previous level; arm only after the first post-reset clock
    // so a switch already high at reset release is not taken as a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= i_lvl;
            r_armed <= 1'b1;
        end
    end

    assign o_rise = i_lvl & ~r_prev & r_armed;

endmodule

// File: rtl/game_flow_ctrl.sv
// Round flow controller: HOME/GAME/PAUSE/END sequencing, scores, timer, winner.
// Latency: state, scores, timer and winner update one cycle after the causing input.
// Backpressure: none; ticks and hits outside GAME are dropped.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int N_PLAYERS  = 2,
    parameter int SCORE_W    = 8,
    parameter int WIN_SCORE  = 10,
    parameter int TIME_W     = 10,
    parameter int ROUND_TIME = 600
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_start,
    input  logic                           i_pause,
    input  logic                           i_tick,
    input  logic [N_PLAYERS-1:0]           i_hit,
    output logic                           o_home_disp,
    output logic                           o_game_disp,
    output logic                           o_pause_disp,
    output logic                           o_end_disp,
    output logic [N_PLAYERS*SCORE_W-1:0]   o_scores,
    output logic [TIME_W-1:0]              o_time_left,
    output logic [win_w(N_PLAYERS)-1:0]    o_winner,
    output logic                           o_tie,
    output logic                           o_round_done
);

    localparam int                 WIN_W     = win_w(N_PLAYERS);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t              r_state;
    logic [TIME_W-1:0]   r_time;
    logic [WIN_W-1:0]    r_winner;
    logic                r_tie;
    logic                r_round_done;
    logic [SCORE_W-1:0]  r_score     [N_PLAYERS];
    logic [SCORE_W-1:0]  w_score_nxt [N_PLAYERS];
    logic [N_PLAYERS-1:0] w_win_hit;
    logic [TIME_W-1:0]   w_time_nxt;
    logic                w_start_rise;
    logic                w_pause_rise;
    logic                w_in_game;
    logic                w_round_start;
    logic                w_end_cond;
    logic [SCORE_W-1:0]  w_best_val;
    logic [WIN_W-1:0]    w_best_idx;
    logic                w_best_tie;

    btn_edge u_start_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_lvl   (i_start),
        .o_rise  (w_start_rise)
    );

    btn_edge u_pause_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_lvl   (i_pause),
        .o_rise  (w_pause_rise)
    );

    assign w_in_game     = (r_state == ST_GAME);
    assign w_round_start = (r_state == ST_HOME) && w_start_rise;

    // Per-player saturating counters; the next value is exposed so the end
    // check and winner scan see hits landing in the final cycle.
    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_score
        assign w_score_nxt[g] = (w_in_game && i_hit[g] && (r_score[g] != SCORE_MAX))
                              ? r_score[g] + 1'b1 : r_score[g];
        assign w_win_hit[g]   = (int'(w_score_nxt[g]) >= WIN_SCORE);
        assign o_scores[g*SCORE_W +: SCORE_W] = r_score[g];

        // Clear on round start, otherwise follow the (possibly incremented) next value.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_score[g] <= '0;
            end else if (w_round_start) begin
                r_score[g] <= '0;
            end else begin
                r_score[g] <= w_score_nxt[g];
            end
        end
    end

    assign w_time_nxt = (w_in_game && i_tick && (r_time != '0)) ? r_time - 1'b1 : r_time;
    assign w_end_cond = (w_time_nxt == '0) || (|w_win_hit);

    // Max scan over final scores; a strictly greater score takes the lead,
    // an equal one marks the top as shared and keeps the lower index.
    always_comb begin
        w_best_val = w_score_nxt[0];
        w_best_idx = '0;
        w_best_tie = 1'b0;
        for (int i = 1; i < N_PLAYERS; i++) begin
            if (w_score_nxt[i] > w_best_val) begin
                w_best_val = w_score_nxt[i];
                w_best_idx = WIN_W'(i);
                w_best_tie = 1'b0;
            end else if (w_score_nxt[i] == w_best_val) begin
                w_best_tie = 1'b1;
            end
        end
    end

    // Round sequencing with timer, result capture and round-done pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_HOME;
            r_time       <= '0;
            r_winner     <= '0;
            r_tie        <= 1'b0;
            r_round_done <= 1'b0;
        end else begin
            r_round_done <= 1'b0;
            case (r_state)
                ST_HOME: begin
                    if (w_start_rise) begin
                        r_state  <= ST_GAME;
                        r_time   <= TIME_W'(ROUND_TIME);
                        r_winner <= '0;
                        r_tie    <= 1'b0;
                    end
                end
                ST_GAME: begin
                    r_time <= w_time_nxt;
                    // End outranks a simultaneous pause press.
                    if (w_end_cond) begin
                        r_state      <= ST_END;
                        r_round_done <= 1'b1;
                        r_winner     <= w_best_idx;
                        r_tie        <= w_best_tie;
                    end else if (w_pause_rise) begin
                        r_state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    // Abort outranks resume when both are pressed together.
                    if (w_start_rise) begin
                        r_state <= ST_HOME;
                    end else if (w_pause_rise) begin
                        r_state <= ST_GAME;
                    end
                end
                ST_END: begin
                    if (w_start_rise) begin
                        r_state <= ST_HOME;
                    end
                end
                default: r_state <= ST_HOME;
            endcase
        end
    end

    assign o_home_disp  = r_state[DISP_HOME];
    assign o_game_disp  = r_state[DISP_GAME];
    assign o_pause_disp = r_state[DISP_PAUSE];
    assign o_end_disp   = r_state[DISP_END];
    assign o_time_left  = r_time;
    assign o_winner     = r_winner;
    assign o_tie        = r_tie;
    assign o_round_done = r_round_done;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: two parameterisations driven by shared stimulus,
// each tracked by a behavioural round model and compared every cycle.
module tb_game_flow_ctrl;

    localparam int NP   = 2;
    localparam int SW_A = 8;
    localparam int WN_A = 10;
    localparam int RT_A = 600;
    localparam int SW_B = 3;
    localparam int WN_B = 9;
    localparam int RT_B = 20;

    localparam int M_HOME  = 0;
    localparam int M_GAME  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_END   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_req = 1'b0;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic tick = 1'b0;
    logic [NP-1:0] hit = '0;

    logic a_home, a_game, a_pause, a_end, a_win, a_tie, a_rd;
    logic [NP*SW_A-1:0] a_scores;
    logic [9:0] a_time;
    logic b_home, b_game, b_pause, b_end, b_win, b_tie, b_rd;
    logic [NP*SW_B-1:0] b_scores;
    logic [9:0] b_time;

    int n_checks = 0;
    int n_errors = 0;

    // model state, index 0 = instance A, 1 = instance B
    int m_state [2];
    int m_score [2][NP];
    int m_time  [2];
    int m_win   [2];
    bit m_tie   [2];
    bit m_rd    [2];
    int p_sw    [2];
    int p_wn    [2];
    int p_rt    [2];
    bit prev_s, prev_p, armed;

    always #5 clk = ~clk;

    game_flow_ctrl #(.N_PLAYERS(NP), .SCORE_W(SW_A), .WIN_SCORE(WN_A), .TIME_W(10), .ROUND_TIME(RT_A)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause), .i_tick(tick), .i_hit(hit),
        .o_home_disp(a_home), .o_game_disp(a_game), .o_pause_disp(a_pause), .o_end_disp(a_end),
        .o_scores(a_scores), .o_time_left(a_time), .o_winner(a_win), .o_tie(a_tie), .o_round_done(a_rd)
    );

    game_flow_ctrl #(.N_PLAYERS(NP), .SCORE_W(SW_B), .WIN_SCORE(WN_B), .TIME_W(10), .ROUND_TIME(RT_B)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause), .i_tick(tick), .i_hit(hit),
        .o_home_disp(b_home), .o_game_disp(b_game), .o_pause_disp(b_pause), .o_end_disp(b_end),
        .o_scores(b_scores), .o_time_left(b_time), .o_winner(b_win), .o_tie(b_tie), .o_round_done(b_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = M_HOME;
            m_time[k]  = 0;
            m_win[k]   = 0;
            m_tie[k]   = 1'b0;
            m_rd[k]    = 1'b0;
            for (int i = 0; i < NP; i++) m_score[k][i] = 0;
        end
        prev_s = 1'b0;
        prev_p = 1'b0;
        armed  = 1'b0;
    endtask

    // Final-score ranking: highest value, first holder wins, shared top is a tie.
    task automatic model_rank(input int k);
        int mx, cnt;
        mx = 0;
        for (int i = 0; i < NP; i++) if (m_score[k][i] > mx) mx = m_score[k][i];
        cnt = 0;
        m_win[k] = -1;
        for (int i = 0; i < NP; i++) begin
            if (m_score[k][i] == mx) begin
                cnt++;
                if (m_win[k] < 0) m_win[k] = i;
            end
        end
        m_tie[k] = (cnt > 1);
    endtask

    task automatic model_step();
        bit se, pe, fin;
        if (!rst_n) begin
            model_reset();
            return;
        end
        se = start && !prev_s && armed;
        pe = pause && !prev_p && armed;
        prev_s = start;
        prev_p = pause;
        armed  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_rd[k] = 1'b0;
            case (m_state[k])
                M_HOME: if (se) begin
                    m_state[k] = M_GAME;
                    m_time[k]  = p_rt[k];
                    m_win[k]   = 0;
                    m_tie[k]   = 1'b0;
                    for (int i = 0; i < NP; i++) m_score[k][i] = 0;
                end
                M_GAME: begin
                    if (tick && m_time[k] > 0) m_time[k]--;
                    fin = (m_time[k] == 0);
                    for (int i = 0; i < NP; i++) begin
                        if (hit[i] && m_score[k][i] < (1 << p_sw[k]) - 1) m_score[k][i]++;
                        if (m_score[k][i] >= p_wn[k]) fin = 1'b1;
                    end
                    if (fin) begin
                        m_state[k] = M_END;
                        m_rd[k]    = 1'b1;
                        model_rank(k);
                    end else if (pe) begin
                        m_state[k] = M_PAUSE;
                    end
                end
                M_PAUSE: begin
                    if (se) m_state[k] = M_HOME;
                    else if (pe) m_state[k] = M_GAME;
                end
                default: if (se) m_state[k] = M_HOME;
            endcase
        end
    endtask

    task automatic check_inst(input int k, input logic [3:0] disp, input logic [15:0] sc,
                              input logic [9:0] tl, input logic w, input logic t, input logic rd);
        logic [15:0] es;
        string n;
        n = (k == 0) ? "A" : "B";
        es = '0;
        for (int i = 0; i < NP; i++) es = es | (16'(m_score[k][i]) << (i * p_sw[k]));
        chk({n, ".disp"}, 32'(disp), 32'(4'b0001 << m_state[k]));
        chk({n, ".scores"}, 32'(sc), 32'(es));
        chk({n, ".time_left"}, 32'(tl), 32'(m_time[k]));
        chk({n, ".winner"}, 32'(w), 32'(m_win[k]));
        chk({n, ".tie"}, 32'(t), 32'(m_tie[k]));
        chk({n, ".round_done"}, 32'(rd), 32'(m_rd[k]));
    endtask

    task automatic check_all();
        check_inst(0, {a_end, a_pause, a_game, a_home}, 16'(a_scores), a_time, a_win, a_tie, a_rd);
        check_inst(1, {b_end, b_pause, b_game, b_home}, 16'(b_scores), b_time, b_win, b_tie, b_rd);
    endtask

    task automatic step(input bit s, input bit p, input bit t, input logic [NP-1:0] h);
        @(negedge clk);
        rst_n = rst_req;
        start = s;
        pause = p;
        tick  = t;
        hit   = h;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        rst_req = 1'b0;
        #1;
        model_reset();
        check_all();
    endtask

    initial begin
        p_sw[0] = SW_A; p_wn[0] = WN_A; p_rt[0] = RT_A;
        p_sw[1] = SW_B; p_wn[1] = WN_B; p_rt[1] = RT_B;
        model_reset();

        // reset state, then start held high across reset release
        repeat (2) step(0, 0, 0, '0);
        repeat (2) step(1, 0, 0, '0);
        rst_req = 1'b1;
        repeat (3) step(1, 0, 0, '0);
        chk("hold_start_home", 32'(a_home), 1);

        // full-length round with no hits
        step(0, 0, 0, '0);
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        chk("round_start_time", 32'(a_time), 600);
        repeat (600) step(0, 0, 1, '0);
        chk("timeout_end", 32'(a_end), 1);
        chk("timeout_time", 32'(a_time), 0);
        chk("timeout_tie", 32'(a_tie), 1);
        chk("timeout_winner", 32'(a_win), 0);

        // ten hits for player 1
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        repeat (10) step(0, 0, 0, 2'b10);
        chk("hits_end", 32'(a_end), 1);
        chk("hits_scores", 32'(a_scores), 32'h0A00);
        chk("hits_winner", 32'(a_win), 1);
        chk("hits_tie", 32'(a_tie), 0);
        chk("sat_scores", 32'(b_scores), 32'b111000);
        chk("sat_still_game", 32'(b_game), 1);

        // pause freezes timer and scores
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        repeat (5) step(0, 0, 1, '0);
        step(0, 1, 0, '0);
        for (int i = 0; i < 50; i++) step(0, 0, 1, (i < 3) ? 2'b01 : 2'b00);
        chk("pause_state", 32'(a_pause), 1);
        chk("pause_time", 32'(a_time), 595);
        chk("pause_scores", 32'(a_scores), 0);
        step(0, 1, 0, '0);
        chk("resume_game", 32'(a_game), 1);

        // last tick together with a hit
        for (int i = 0; i < 700 && m_time[0] > 1; i++) step(0, 0, 1, '0);
        chk("b_timer_end", 32'(b_end), 1);
        chk("b_timer_winner", 32'(b_win), 1);
        step(0, 0, 1, 2'b01);
        chk("last_tick_end", 32'(a_end), 1);
        chk("last_tick_time", 32'(a_time), 0);
        chk("last_tick_score0", 32'(a_scores[7:0]), 1);

        // reset in the middle of a round
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        step(1, 0, 0, '0);
        repeat (3) step(0, 0, 0, 2'b11);
        async_reset();
        chk("rst_mid_home", 32'(a_home), 1);
        chk("rst_mid_scores", 32'(a_scores), 0);
        repeat (2) step(0, 0, 0, '0);
        rst_req = 1'b1;
        step(0, 0, 0, '0);

        // randomized play
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) rst_req = 1'b0;
            else if (!rst_req && $urandom_range(0, 2) == 0) rst_req = 1'b1;
            step($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                 {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
